vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for VGA-style displays. A raw pixel position
//   (x, y) counts across the full line/frame including blanking, and the
//   sync and display-enable outputs are decoded from that position. The
//   decodes are registered together with the position, so hsync, vsync, de,
//   x and y always describe the same pixel.
//
// Configuration macro:
//   VGA_TIMING_GEN_CLKDIV_EN
//     defined   : the pixel tick is an internal divide-by-2 of clk and the
//                 pix_ce port does not exist.
//     undefined : the pixel tick is the pix_ce input, sampled every clk.
//
// Ports:
//   clk         in   1   system clock
//   rst         in   1   asynchronous reset, active low
//   pix_ce      in   1   pixel tick enable (only when the macro is undefined)
//   hsync       out  1   horizontal sync, active level H_POL
//   vsync       out  1   vertical sync, active level V_POL
//   de          out  1   active-display flag
//   x           out  CW  current pixel column (raw, including blanking)
//   y           out  CW  current line (raw, including blanking)
//   line_start  out  1   one-clk pulse when x becomes 0
//   frame_start out  1   one-clk pulse when (x,y) becomes (0,0)
//   pix_tick    out  1   registered copy of the pixel tick
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int CW        = 12
) (
    input  logic          clk,
    input  logic          rst,
`ifndef VGA_TIMING_GEN_CLKDIV_EN
    input  logic          pix_ce,
`endif
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          pix_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam int HS_BEGIN = H_DISPLAY + H_FP;
    localparam int HS_END   = H_DISPLAY + H_FP + H_SYNC;
    localparam int VS_BEGIN = V_DISPLAY + V_FP;
    localparam int VS_END   = V_DISPLAY + V_FP + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    localparam logic HS_ACT = (H_POL != 0);
    localparam logic VS_ACT = (V_POL != 0);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          pix_tick_q, pix_tick_d;

    // Position the counters move to on this tick; the decodes below are
    // taken from this value so they land in the same register as x/y.
    logic [CW-1:0] x_nxt;
    logic [CW-1:0] y_nxt;

    logic          tick;

    // -----------------------------------------------------------------------
    // Pixel tick source
    // -----------------------------------------------------------------------
`ifdef VGA_TIMING_GEN_CLKDIV_EN
    // Toggle starts at 0 out of reset, so it is first high during the
    // second clk after release; that edge is the first pixel tick.
    logic div_q, div_d;

    always_comb begin
        div_d = ~div_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = div_q;
`else
    assign tick = pix_ce;
`endif

    // -----------------------------------------------------------------------
    // Position decodes
    // -----------------------------------------------------------------------
    function automatic logic hsync_at(input logic [CW-1:0] xv);
        if ((int'(xv) >= HS_BEGIN) && (int'(xv) < HS_END)) begin
            return HS_ACT;
        end
        return ~HS_ACT;
    endfunction

    function automatic logic vsync_at(input logic [CW-1:0] yv);
        if ((int'(yv) >= VS_BEGIN) && (int'(yv) < VS_END)) begin
            return VS_ACT;
        end
        return ~VS_ACT;
    endfunction

    function automatic logic de_at(input logic [CW-1:0] xv, input logic [CW-1:0] yv);
        return (int'(xv) < H_DISPLAY) && (int'(yv) < V_DISPLAY);
    endfunction

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        x_nxt         = x_q;
        y_nxt         = y_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        pix_tick_d    = tick;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    x_nxt   = '0;
                    y_nxt   = '0;
                end
                RUN: begin
                    if (x_q == H_LAST) begin
                        x_nxt = '0;
                        y_nxt = (y_q == V_LAST) ? '0 : y_q + 1'b1;
                    end else begin
                        x_nxt = x_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            x_d           = x_nxt;
            y_d           = y_nxt;
            hsync_d       = hsync_at(x_nxt);
            vsync_d       = vsync_at(y_nxt);
            de_d          = de_at(x_nxt, y_nxt);
            line_start_d  = (x_nxt == '0);
            frame_start_d = (x_nxt == '0) && (y_nxt == '0);
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~HS_ACT;
            vsync_q       <= ~VS_ACT;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pix_tick_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            pix_tick_q    <= pix_tick_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign pix_tick    = pix_tick_q;

endmodule
